// File: rtl/des_pkg.sv
// DES f-function constants and helpers.
//   E_TABLE : 32->48 expansion, 1-based DES bit numbers, MSB-first
//   P_TABLE : 32->32 permutation, same numbering (padded to the shared table type)
//   SBOX    : eight 64-entry S-boxes, row-major (index = row*16 + col)
//   des_perm: applies a 1-based MSB-first selection table to a source vector
package des_pkg;

    typedef logic [5:0] perm_tbl_t [48];

    localparam perm_tbl_t E_TABLE = '{
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd4,  6'd5,
        6'd6,  6'd7,  6'd8,  6'd9,  6'd8,  6'd9,  6'd10, 6'd11,
        6'd12, 6'd13, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd24, 6'd25, 6'd26, 6'd27,
        6'd28, 6'd29, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
    };

    // Only the first 32 entries are meaningful; the tail pads P to the
    // same table type as E so a single permutation helper serves both.
    localparam perm_tbl_t P_TABLE = '{
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25,
        6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,
        6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0
    };

    localparam logic [3:0] SBOX [8][64] = '{
        '{4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
          4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
          4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
          4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13},
        '{4'd15, 4'd1,  4'd8,  4'd14, 4'd6,  4'd11, 4'd3,  4'd4,  4'd9,  4'd7,  4'd2,  4'd13, 4'd12, 4'd0,  4'd5,  4'd10,
          4'd3,  4'd13, 4'd4,  4'd7,  4'd15, 4'd2,  4'd8,  4'd14, 4'd12, 4'd0,  4'd1,  4'd10, 4'd6,  4'd9,  4'd11, 4'd5,
          4'd0,  4'd14, 4'd7,  4'd11, 4'd10, 4'd4,  4'd13, 4'd1,  4'd5,  4'd8,  4'd12, 4'd6,  4'd9,  4'd3,  4'd2,  4'd15,
          4'd13, 4'd8,  4'd10, 4'd1,  4'd3,  4'd15, 4'd4,  4'd2,  4'd11, 4'd6,  4'd7,  4'd12, 4'd0,  4'd5,  4'd14, 4'd9},
        '{4'd10, 4'd0,  4'd9,  4'd14, 4'd6,  4'd3,  4'd15, 4'd5,  4'd1,  4'd13, 4'd12, 4'd7,  4'd11, 4'd4,  4'd2,  4'd8,
          4'd13, 4'd7,  4'd0,  4'd9,  4'd3,  4'd4,  4'd6,  4'd10, 4'd2,  4'd8,  4'd5,  4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
          4'd13, 4'd6,  4'd4,  4'd9,  4'd8,  4'd15, 4'd3,  4'd0,  4'd11, 4'd1,  4'd2,  4'd12, 4'd5,  4'd10, 4'd14, 4'd7,
          4'd1,  4'd10, 4'd13, 4'd0,  4'd6,  4'd9,  4'd8,  4'd7,  4'd4,  4'd15, 4'd14, 4'd3,  4'd11, 4'd5,  4'd2,  4'd12},
        '{4'd7,  4'd13, 4'd14, 4'd3,  4'd0,  4'd6,  4'd9,  4'd10, 4'd1,  4'd2,  4'd8,  4'd5,  4'd11, 4'd12, 4'd4,  4'd15,
          4'd13, 4'd8,  4'd11, 4'd5,  4'd6,  4'd15, 4'd0,  4'd3,  4'd4,  4'd7,  4'd2,  4'd12, 4'd1,  4'd10, 4'd14, 4'd9,
          4'd10, 4'd6,  4'd9,  4'd0,  4'd12, 4'd11, 4'd7,  4'd13, 4'd15, 4'd1,  4'd3,  4'd14, 4'd5,  4'd2,  4'd8,  4'd4,
          4'd3,  4'd15, 4'd0,  4'd6,  4'd10, 4'd1,  4'd13, 4'd8,  4'd9,  4'd4,  4'd5,  4'd11, 4'd12, 4'd7,  4'd2,  4'd14},
        '{4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,  4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9,
          4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,  4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6,
          4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,  4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14,
          4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13, 4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3},
        '{4'd12, 4'd1,  4'd10, 4'd15, 4'd9,  4'd2,  4'd6,  4'd8,  4'd0,  4'd13, 4'd3,  4'd4,  4'd14, 4'd7,  4'd5,  4'd11,
          4'd10, 4'd15, 4'd4,  4'd2,  4'd7,  4'd12, 4'd9,  4'd5,  4'd6,  4'd1,  4'd13, 4'd14, 4'd0,  4'd11, 4'd3,  4'd8,
          4'd9,  4'd14, 4'd15, 4'd5,  4'd2,  4'd8,  4'd12, 4'd3,  4'd7,  4'd0,  4'd4,  4'd10, 4'd1,  4'd13, 4'd11, 4'd6,
          4'd4,  4'd3,  4'd2,  4'd12, 4'd9,  4'd5,  4'd15, 4'd10, 4'd11, 4'd14, 4'd1,  4'd7,  4'd6,  4'd0,  4'd8,  4'd13},
        '{4'd4,  4'd11, 4'd2,  4'd14, 4'd15, 4'd0,  4'd8,  4'd13, 4'd3,  4'd12, 4'd9,  4'd7,  4'd5,  4'd10, 4'd6,  4'd1,
          4'd13, 4'd0,  4'd11, 4'd7,  4'd4,  4'd9,  4'd1,  4'd10, 4'd14, 4'd3,  4'd5,  4'd12, 4'd2,  4'd15, 4'd8,  4'd6,
          4'd1,  4'd4,  4'd11, 4'd13, 4'd12, 4'd3,  4'd7,  4'd14, 4'd10, 4'd15, 4'd6,  4'd8,  4'd0,  4'd5,  4'd9,  4'd2,
          4'd6,  4'd11, 4'd13, 4'd8,  4'd1,  4'd4,  4'd10, 4'd7,  4'd9,  4'd5,  4'd0,  4'd15, 4'd14, 4'd2,  4'd3,  4'd12},
        '{4'd13, 4'd2,  4'd8,  4'd4,  4'd6,  4'd15, 4'd11, 4'd1,  4'd10, 4'd9,  4'd3,  4'd14, 4'd5,  4'd0,  4'd12, 4'd7,
          4'd1,  4'd15, 4'd13, 4'd8,  4'd10, 4'd3,  4'd7,  4'd4,  4'd12, 4'd5,  4'd6,  4'd11, 4'd0,  4'd14, 4'd9,  4'd2,
          4'd7,  4'd11, 4'd4,  4'd1,  4'd9,  4'd12, 4'd14, 4'd2,  4'd0,  4'd6,  4'd10, 4'd13, 4'd15, 4'd3,  4'd5,  4'd8,
          4'd2,  4'd1,  4'd14, 4'd7,  4'd4,  4'd10, 4'd8,  4'd13, 4'd15, 4'd12, 4'd9,  4'd0,  4'd3,  4'd5,  4'd6,  4'd11}
    };

    // Result bit (dst_w-i) takes source DES bit tbl[i-1], i.e. source
    // vector index (src_w - tbl[i-1]). Unused upper result bits are zero.
    function automatic logic [47:0] des_perm(
        input logic [47:0]  src,
        input int unsigned  src_w,
        input perm_tbl_t    tbl,
        input int unsigned  dst_w
    );
        logic [47:0] dst;
        logic [5:0]  si;
        logic [5:0]  di;
        dst = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            if (i < dst_w) begin
                si = 6'(src_w - 32'(tbl[i]));
                di = 6'(dst_w - 1 - i);
                dst[di] = src[si];
            end
        end
        return dst;
    endfunction

endpackage

// File: rtl/des_sbox.sv
// One DES S-box lookup.
//   sel : which S-box (0 = S1 ... 7 = S8)
//   b   : 6-bit group, b[5] = DES b1, b[0] = DES b6
//   s   : 4-bit S-box output
module des_sbox
    import des_pkg::*;
(
    input  logic [2:0] sel,
    input  logic [5:0] b,
    output logic [3:0] s
);

    // Row comes from the outer bits {b1,b6}, column from the inner four.
    logic [5:0] idx;

    always_comb begin
        idx = {b[5], b[0], b[4:1]};
        s   = SBOX[sel][idx];
    end

endmodule

// File: rtl/f_function.sv
// DES round f-function f(R,K) = P(S(E(R) xor K)) with one output register.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : data_in/key qualify this cycle
//   data_in   : 32-bit R half-block, bit 31 = DES bit 1
//   key       : 48-bit round subkey, bit 47 = DES bit 1
//   out_valid : data_out holds a new result
//   data_out  : f(R,K), held while in_valid is low
module f_function
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] data_in,
    input  logic [47:0] key,
    output logic        out_valid,
    output logic [31:0] data_out
);

    logic [47:0] expanded;
    logic [47:0] mixed;
    logic [31:0] s_out;
    logic [31:0] p_out;

    assign expanded = des_perm({16'h0, data_in}, 32, E_TABLE, 48);
    assign mixed    = expanded ^ key;

    // S1 takes the top six bits of the mixed word and drives the top nibble.
    for (genvar g = 0; g < 8; g++) begin : g_sbox
        des_sbox u_sbox (
            .sel (3'(g)),
            .b   (mixed[47-6*g -: 6]),
            .s   (s_out[31-4*g -: 4])
        );
    end

    assign p_out = 32'(des_perm({16'h0, s_out}, 32, P_TABLE, 32));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= p_out;
            end
        end
    end

endmodule

// File: tb/tb_f_function.sv
module tb_f_function;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] data_in;
    logic [47:0] key;
    logic        out_valid;
    logic [31:0] data_out;

    int unsigned total_cnt;
    int unsigned pass_cnt;

    f_function dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .key       (key),
        .out_valid (out_valid),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Software DES f reference, tables straight from FIPS 46-3.
    int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
                     12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
                     22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    int S_T [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    // Works on plain integers: DES bit n of a W-bit word is (v >> (W-n)) & 1.
    function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
        longint unsigned x;
        longint unsigned rr;
        longint unsigned sv;
        longint unsigned p;
        int b;
        int row;
        int col;
        rr = longint'({32'h0, r});
        x  = 0;
        for (int i = 0; i < 48; i++)
            x = (x << 1) | ((rr >> (32 - E_T[i])) & 64'd1);
        x = x ^ longint'({16'h0, k});
        sv = 0;
        for (int j = 0; j < 8; j++) begin
            b   = int'((x >> (42 - 6 * j)) & 64'h3f);
            row = (b / 32) * 2 + (b % 2);
            col = (b / 2) % 16;
            sv  = (sv << 4) | longint'(S_T[j][row * 16 + col]);
        end
        p = 0;
        for (int i = 0; i < 32; i++)
            p = (p << 1) | ((sv >> (32 - P_T[i])) & 64'd1);
        return 32'(p);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_dout;
    logic        exp_valid;

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;

        // Reset held with live, toggling inputs
        rst_n    = 1'b0;
        in_valid = 1'b1;
        data_in  = $urandom;
        key      = {16'($urandom), $urandom};
        #2;
        chk("reset_valid_t0", {31'h0, out_valid}, 32'h0);
        chk("reset_data_t0", data_out, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("reset_valid", {31'h0, out_valid}, 32'h0);
            chk("reset_data", data_out, 32'h0);
            data_in = $urandom;
            key     = {16'($urandom), $urandom};
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        chk("idle_valid", {31'h0, out_valid}, 32'h0);
        chk("idle_data", data_out, 32'h0);

        // Zero vector then FIPS round-1 vector back to back
        in_valid = 1'b1;
        data_in  = 32'h0;
        key      = 48'h0;
        step();
        chk("zero_valid", {31'h0, out_valid}, 32'h1);
        chk("zero_data", data_out, 32'hD8D8DBBC);
        data_in = 32'hF0AAF0AA;
        key     = 48'h1B02EFFC7072;
        step();
        chk("fips_valid", {31'h0, out_valid}, 32'h1);
        chk("fips_data", data_out, 32'h234AA9BB);
        in_valid = 1'b0;
        data_in  = $urandom;
        key      = {16'($urandom), $urandom};
        step();
        chk("drop_valid", {31'h0, out_valid}, 32'h0);
        chk("hold_data", data_out, 32'h234AA9BB);
        data_in = $urandom;
        step();
        chk("hold_valid2", {31'h0, out_valid}, 32'h0);
        chk("hold_data2", data_out, 32'h234AA9BB);

        // Reset between two pipelined vectors
        in_valid = 1'b1;
        data_in  = 32'h0;
        key      = 48'h0;
        step();
        chk("mid_first_data", data_out, 32'hD8D8DBBC);
        data_in = 32'hF0AAF0AA;
        key     = 48'h1B02EFFC7072;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_async_data", data_out, 32'h0);
        step();
        chk("mid_held_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_held_data", data_out, 32'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        chk("mid_post_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_post_data", data_out, 32'h0);

        // Random sweep against the reference model, with occasional idle cycles
        exp_dout = 32'h0;
        for (int n = 0; n <= 10000; n++) begin
            if (n == 0) begin
                data_in  = 32'h13345779;
                key      = 48'h57799BBCDFF1;
                in_valid = 1'b1;
            end else begin
                data_in  = $urandom;
                key      = {16'($urandom), $urandom};
                in_valid = ($urandom_range(7) != 0);
            end
            exp_valid = in_valid;
            if (in_valid)
                exp_dout = ref_f(data_in, key);
            step();
            chk("rand_valid", {31'h0, out_valid}, {31'h0, exp_valid});
            chk("rand_data", data_out, exp_dout);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
